seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment display.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_scan_driver_hex_to_seg7.sv | 11 +
 rtl/seg7_scan_driver.sv | 98 +++++++++
 tb/tb_seg7_scan_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit order and the
// active-high glyph table for the 16 hex digits.
package seg7_pkg;

  // Bit order of every segment vector, MSB first: {a,b,c,d,e,f,g}.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b0000000;

  // Entry [n] is the active-high glyph for hex digit n (packed, so F is listed first).
  localparam logic [15:0][6:0] SEG_CODES = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output seg_t       o_seg
);

  assign o_seg = SEG_CODES[i_hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadow-latched hex value, one digit per
// refresh slot, leading-zero blanking, decimal points and anti-ghost dead time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_shadow_val;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [DIGITS-1:0]     r_an;

  logic [3:0]            w_digit;
  seg_t                  w_dec;
  logic [DIGITS-1:0]     w_blank;
  logic                  w_blanked;
  logic                  w_dead;
  logic                  w_dp_req;
  logic [DIGITS-1:0]     w_hot;

  assign w_digit   = r_shadow_val[{r_idx, 2'b00} +: 4];
  assign w_blanked = w_blank[r_idx];
  assign w_dp_req  = r_shadow_dp[r_idx];
  assign w_dead    = (r_presc < DEAD_END);
  assign w_hot     = DIGITS'(1'b1) << r_idx;

  hex_to_seg7 u_dec (
    .i_hex (w_digit),
    .o_seg (w_dec)
  );

  // A digit blanks while it and everything above it are zero with no dp set; digit 0 never blanks.
  always_comb begin
    logic lz_run;
    lz_run  = 1'b1;
    w_blank = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run & (r_shadow_val[4*i +: 4] == 4'h0) & ~r_shadow_dp[i];
      w_blank[i] = lz_run & blank_lz;
    end
  end

  // Prescaler, scan index, shadow latch and polarity-adjusted output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= {PW{1'b0}};
      r_idx        <= {IW{1'b0}};
      r_shadow_val <= {(4*DIGITS){1'b0}};
      r_shadow_dp  <= {DIGITS{1'b0}};
      r_seg        <= SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
      r_dp         <= SEG_ACTIVE_LOW;
      r_an         <= {DIGITS{AN_ACTIVE_LOW}};
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= {PW{1'b0}};
        r_idx   <= (r_idx == IDX_LAST) ? {IW{1'b0}} : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
      end
      r_seg <= (w_blanked ? SEG_OFF : w_dec) ^ {7{SEG_ACTIVE_LOW}};
      r_dp  <= (~w_blanked & w_dp_req) ^ SEG_ACTIVE_LOW;
      r_an  <= ((w_blanked | w_dead) ? {DIGITS{1'b0}} : w_hot) ^ {DIGITS{AN_ACTIVE_LOW}};
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus randomized
// traffic, compared against a behavioural display model.
module tb_seg7_scan_driver;

  localparam int RD   = 8;
  localparam int DEAD = 2;
  localparam int ND   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;

  logic [6:0]  seg, seg_i;
  logic        dp, dp_i;
  logic [3:0]  an, an_i;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD),
                     .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an)
  );

  seg7_scan_driver #(.DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD),
                     .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)) dut_inv (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg(seg_i), .dp(dp_i), .an(an_i)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011;  10: return 7'b1110111; 11: return 7'b0011111;
      12: return 7'b1001110; 13: return 7'b0111101; 14: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic int nib(input logic [15:0] v, input int k);
    return int'((v >> (4 * k)) & 16'h000F);
  endfunction

  // Display as the specification describes it: {an, seg, dp} for one scan state.
  function automatic logic [11:0] model_out(input int presc, input int idx, input logic [15:0] v,
                                            input logic [3:0] d, input logic blz);
    bit blanked;
    logic [3:0] an_v;
    blanked = 1'b0;
    if (blz && idx > 0) begin
      blanked = 1'b1;
      for (int j = idx; j < ND; j++)
        if (nib(v, j) != 0 || d[j]) blanked = 1'b0;
    end
    an_v = (blanked || presc < DEAD) ? 4'hF : ~(4'b0001 << idx);
    return {an_v, blanked ? 7'b0000000 : seg_of(nib(v, idx)), blanked ? 1'b0 : d[idx]};
  endfunction

  int          m_presc = 0;
  int          m_idx = 0;
  logic [15:0] m_val = 16'h0000;
  logic [3:0]  m_dp = 4'h0;
  logic [11:0] exp_v = 12'hF00;

  // Reference model: expected outputs come from the state seen before each edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_v   = 12'b1111_0000000_0;
      m_presc = 0;
      m_idx   = 0;
      m_val   = 16'h0000;
      m_dp    = 4'h0;
    end else begin
      exp_v = model_out(m_presc, m_idx, m_val, m_dp, blank_lz);
      if (load) begin
        m_val = value;
        m_dp  = dp_in;
      end
      m_presc = (m_presc + 1) % RD;
      if (m_presc == 0) m_idx = (m_idx + 1) % ND;
    end
  end

  task automatic test_reset();
    rst = 1'b1; load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== 12'b1111_0000000_0 || {an_i, seg_i, dp_i} !== 12'b0000_1111111_1) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h/%h expected f00/0ff", k, {an, seg, dp}, {an_i, seg_i, dp_i});
      end
    end
  endtask

  task automatic test_scan();
    logic [15:0] v;
    v = 16'h12AF;
    rst = 1'b1; @(negedge clk);
    rst = 1'b0; load = 1'b1; value = v; dp_in = 4'h0; blank_lz = 1'b0;
    @(negedge clk);
    load = 1'b0;
    for (int n = 1; n < 40; n++) begin
      int s, c;
      logic [3:0] an_e;
      @(negedge clk);
      s = n / RD; c = n % RD;
      an_e = (c < DEAD) ? 4'hF : ~(4'b0001 << (s % ND));
      checks++;
      if (an !== an_e || seg !== seg_of(nib(v, s % ND)) || {an, seg, dp, an_i, seg_i, dp_i} !== {exp_v, ~exp_v}) begin
        errors++;
        $display("FAIL scan slot %0d cyc %0d: got an=%b seg=%b model=%h expected an=%b seg=%b",
                 s, c, an, seg, exp_v, an_e, seg_of(nib(v, s % ND)));
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vals [3];
    logic [3:0]  dps [3];
    vals[0] = 16'h0030; dps[0] = 4'b0000;
    vals[1] = 16'h0000; dps[1] = 4'b0000;
    vals[2] = 16'h0005; dps[2] = 4'b0100;
    blank_lz = 1'b1;
    for (int t = 0; t < 3; t++) begin
      int bad, dp2;
      bad = 0; dp2 = 0;
      load = 1'b1; value = vals[t]; dp_in = dps[t];
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      for (int n = 0; n < 4 * RD; n++) begin
        @(negedge clk);
        if (an == 4'b0111) bad++;
        if (t == 0 && an == 4'b1011) bad++;
        if (t == 1 && an != 4'b1111 && an != 4'b1110) bad++;
        if (an == 4'b1110 && seg !== seg_of(nib(vals[t], 0))) bad++;
        if (t == 2 && an == 4'b1011 && dp && seg == 7'b1111110) dp2++;
        checks++;
        if ({an, seg, dp, an_i, seg_i, dp_i} !== {exp_v, ~exp_v}) begin
          errors++;
          $display("FAIL blank t%0d cyc %0d: got %h/%h expected %h", t, n, {an, seg, dp}, {an_i, seg_i, dp_i}, exp_v);
        end
      end
      checks++;
      if (bad != 0 || (t == 2 && dp2 == 0)) begin
        errors++;
        $display("FAIL blank_pattern t%0d: got %0d bad cycles, %0d dp2 cycles expected 0 bad and dp2 seen", t, bad, dp2);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_load_at_wrap();
    int guard, nidx;
    logic [15:0] v;
    v = 16'h4321;
    guard = 0;
    while (m_presc != RD - 1 && guard < 2 * RD) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (m_presc != RD - 1) begin
      errors++;
      $display("FAIL wrap_wait: got presc %0d expected %0d", m_presc, RD - 1);
    end
    load = 1'b1; value = v; dp_in = 4'h0;
    @(negedge clk);
    load = 1'b0; nidx = m_idx;
    @(negedge clk);
    checks++;
    if (seg !== seg_of(nib(v, nidx)) || {an, seg, dp, an_i, seg_i, dp_i} !== {exp_v, ~exp_v}) begin
      errors++;
      $display("FAIL load_at_wrap: got seg=%b expected %b", seg, seg_of(nib(v, nidx)));
    end
  endtask

  task automatic test_rst_mid();
    blank_lz = 1'b0;
    repeat (RD + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({an, seg, dp} !== 12'b1111_0000000_0) begin
      errors++;
      $display("FAIL rst_mid: got %h expected f00", {an, seg, dp});
    end
    for (int c = 0; c < RD + 2; c++) begin
      logic [3:0] an_e;
      @(negedge clk);
      an_e = (c % RD < DEAD) ? 4'hF : ((c < RD) ? 4'b1110 : 4'b1101);
      checks++;
      if (an !== an_e || seg !== 7'b1111110 || {an_i, seg_i, dp_i} !== ~exp_v) begin
        errors++;
        $display("FAIL rst_resume cyc %0d: got an=%b seg=%b expected an=%b seg=1111110", c, an, seg, an_e);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [15:0] v;
      v = 16'h0000;
      for (int k = 0; k < ND; k++)
        if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 149) == 0);
      load     = ($urandom_range(0, 9) == 0) || (m_presc == RD - 1 && $urandom_range(0, 1) == 1);
      value    = v;
      dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      blank_lz = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({an, seg, dp, an_i, seg_i, dp_i} !== {exp_v, ~exp_v}) begin
        errors++;
        $display("FAIL random cyc %0d: got %h/%h expected %h", n, {an, seg, dp}, {an_i, seg_i, dp_i}, exp_v);
      end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_load_at_wrap();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
